// File: rtl/sf_pkg.sv
// Shared types and constants for the stereo front-end multiplier-sharing controller.
// Consumers: sf_scale_sat and sf_mult_share_ctrl.
package sf_pkg;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned K_W    = 4;
  localparam int unsigned MB_W   = 5;
  localparam int unsigned PROD_W = 23;
  localparam int unsigned EXT_W  = 24;
  localparam int unsigned SUM_W  = 19;

  localparam int SAT18_MAX = 131071;
  localparam int SAT18_MIN = -131072;

  localparam int unsigned SCALE_SHIFT = 3;
  localparam int unsigned ROUND_BIAS  = 4;

  typedef enum logic [2:0] {
    IDLE,
    START_S,
    WAIT_S,
    START_D,
    WAIT_D,
    DONE
  } sf_state_e;

  // Clamp a wide signed value into the 18-bit audio range.
  function automatic logic signed [DATA_W-1:0] sat18(input logic signed [EXT_W-1:0] x);
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    hi = EXT_W'(SAT18_MAX);
    lo = EXT_W'(SAT18_MIN);
    if (x > hi) begin
      return hi[DATA_W-1:0];
    end else if (x < lo) begin
      return lo[DATA_W-1:0];
    end
    return x[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sf_scale_sat.sv
// Scales a 23-bit signed product by 1/8 and saturates to 18 bits.
// Build option SF_ROUND_EN selects round-half-up; otherwise truncation toward -inf.
module sf_scale_sat
  import sf_pkg::*;
(
  input  logic signed [PROD_W-1:0] p_i,
  output logic signed [DATA_W-1:0] q_o
);

  logic signed [EXT_W-1:0] ext_c;
  logic signed [EXT_W-1:0] shr_c;

  always_comb begin
    ext_c = EXT_W'(p_i);
`ifdef SF_ROUND_EN
    ext_c = ext_c + EXT_W'(ROUND_BIAS);
`else
    ext_c = ext_c;
`endif
    shr_c = ext_c >>> SCALE_SHIFT;
    q_o   = sat18(shr_c);
  end

endmodule

// File: rtl/sf_mult_share_ctrl.sv
// Time-shares one external sequential multiplier for the (L+R)*Ks and (L-R)*Kd gains.
// Rounding of the 1/8 scaling is selected by SF_ROUND_EN (see sf_scale_sat).
module sf_mult_share_ctrl
  import sf_pkg::*;
#(
  parameter int unsigned TM_MIN = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] LEFT,
  input  logic signed [DATA_W-1:0] RIGHT,
  input  logic        [K_W-1:0]    Ks,
  input  logic        [K_W-1:0]    Kd,
  output logic                     busy,
  output logic                     overrun,
  output logic                     mult_start,
  output logic signed [DATA_W-1:0] mult_a,
  output logic signed [MB_W-1:0]   mult_b,
  input  logic                     mult_ready,
  input  logic signed [PROD_W-1:0] mult_r,
  output logic signed [DATA_W-1:0] LI_in_LpR,
  output logic signed [DATA_W-1:0] LI_in_LmR,
  output logic                     out_valid
);

  localparam int unsigned CNT_W = $clog2(TM_MIN + 2);

  sf_state_e                state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] diff_q, diff_d;
  logic [K_W-1:0]           kd_q, kd_d;
  logic signed [DATA_W-1:0] lpr_hold_q, lpr_hold_d;
  logic signed [DATA_W-1:0] lmr_hold_q, lmr_hold_d;
  logic signed [DATA_W-1:0] mult_a_q, mult_a_d;
  logic signed [MB_W-1:0]   mult_b_q, mult_b_d;
  logic                     mult_start_q, mult_start_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic signed [DATA_W-1:0] li_lpr_q, li_lpr_d;
  logic signed [DATA_W-1:0] li_lmr_q, li_lmr_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [SUM_W-1:0]  sum19_c;
  logic signed [SUM_W-1:0]  diff19_c;
  logic signed [DATA_W-1:0] scaled_c;
  logic                     ready_ok_c;

  // One scaler serves both captures; only one product is ever in flight.
  sf_scale_sat u_scale (
    .p_i (mult_r),
    .q_o (scaled_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      diff_q       <= '0;
      kd_q         <= '0;
      lpr_hold_q   <= '0;
      lmr_hold_q   <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      mult_start_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      li_lpr_q     <= '0;
      li_lmr_q     <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      kd_q         <= kd_d;
      lpr_hold_q   <= lpr_hold_d;
      lmr_hold_q   <= lmr_hold_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      mult_start_q <= mult_start_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      li_lpr_q     <= li_lpr_d;
      li_lmr_q     <= li_lmr_d;
      out_valid_q  <= out_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    kd_d         = kd_q;
    lpr_hold_d   = lpr_hold_q;
    lmr_hold_d   = lmr_hold_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    mult_start_d = 1'b0;
    overrun_d    = 1'b0;
    li_lpr_d     = li_lpr_q;
    li_lmr_d     = li_lmr_q;
    out_valid_d  = 1'b0;

    sum19_c    = {LEFT[DATA_W-1], LEFT} + {RIGHT[DATA_W-1], RIGHT};
    diff19_c   = {LEFT[DATA_W-1], LEFT} - {RIGHT[DATA_W-1], RIGHT};
    // cnt_q counts cycles elapsed since the start cycle, saturating.
    ready_ok_c = mult_ready && (cnt_q >= CNT_W'(TM_MIN));

    unique case (state_q)
      IDLE: begin
        if (sample_valid) begin
          mult_a_d     = sat18(EXT_W'(sum19_c));
          mult_b_d     = {1'b0, Ks};
          diff_d       = sat18(EXT_W'(diff19_c));
          kd_d         = Kd;
          cnt_d        = '0;
          mult_start_d = 1'b1;
          state_d      = START_S;
        end
      end
      START_S: begin
        cnt_d   = CNT_W'(1);
        state_d = WAIT_S;
      end
      WAIT_S: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (ready_ok_c) begin
          lpr_hold_d   = scaled_c;
          mult_a_d     = diff_q;
          mult_b_d     = {1'b0, kd_q};
          mult_start_d = 1'b1;
          state_d      = START_D;
        end
      end
      START_D: begin
        cnt_d   = CNT_W'(1);
        state_d = WAIT_D;
      end
      WAIT_D: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        // The DONE update is folded into this exit so out_valid lands in the first IDLE cycle.
        if (ready_ok_c) begin
          lmr_hold_d  = scaled_c;
          li_lpr_d    = lpr_hold_q;
          li_lmr_d    = scaled_c;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      DONE: begin
        li_lpr_d    = lpr_hold_q;
        li_lmr_d    = lmr_hold_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (sample_valid && (state_q != IDLE)) overrun_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign mult_start = mult_start_q;
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign LI_in_LpR  = li_lpr_q;
  assign LI_in_LmR  = li_lmr_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_sf_mult_share_ctrl.sv
// Directed bench for sf_mult_share_ctrl with a behavioural sequential multiplier.
// Expected results follow SF_ROUND_EN when it is defined for the build.
module tb_sf_mult_share_ctrl;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [17:0] LEFT = '0;
  logic signed [17:0] RIGHT = '0;
  logic [3:0]         Ks = '0;
  logic [3:0]         Kd = '0;
  logic               busy, overrun, mult_start, out_valid;
  logic signed [17:0] mult_a;
  logic signed [4:0]  mult_b;
  logic               mult_ready;
  logic signed [22:0] mult_r;
  logic signed [17:0] LI_in_LpR, LI_in_LmR;

  int n_cmp = 0;
  int n_err = 0;
  int tm_model = 4;
  int rem;
  int cyc;
  int pulses;

  sf_mult_share_ctrl #(.TM_MIN(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .LEFT         (LEFT),
    .RIGHT        (RIGHT),
    .Ks           (Ks),
    .Kd           (Kd),
    .busy         (busy),
    .overrun      (overrun),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_ready   (mult_ready),
    .mult_r       (mult_r),
    .LI_in_LpR    (LI_in_LpR),
    .LI_in_LmR    (LI_in_LmR),
    .out_valid    (out_valid)
  );

  always #5 clock = ~clock;

  // Multiplier model: ready rises tm_model cycles after the start cycle and stays high.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mult_ready <= 1'b0;
      mult_r     <= '0;
      rem        <= 0;
    end else if (mult_start) begin
      mult_r     <= mult_a * mult_b;
      mult_ready <= (tm_model <= 1);
      rem        <= tm_model - 1;
    end else if (rem > 1) begin
      rem <= rem - 1;
    end else if (rem == 1) begin
      mult_ready <= 1'b1;
      rem        <= 0;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample; return the cycle index (acceptance = 0) of the out_valid pulse.
  task automatic run_sample(input logic signed [17:0] l, input logic signed [17:0] r,
                            input logic [3:0] ks, input logic [3:0] kd, output int c);
    @(negedge clock);
    LEFT = l; RIGHT = r; Ks = ks; Kd = kd; sample_valid = 1'b1;
    @(posedge clock);
    #1 sample_valid = 1'b0;
    c = 1;
    while (!out_valid && c < 100) begin
      @(posedge clock);
      #1 c++;
    end
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_start", mult_start, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_lpr", LI_in_LpR, 0);
    chk("rst_lmr", LI_in_LmR, 0);
    chk("rst_out_valid", out_valid, 0);
    @(negedge clock) reset = 1'b0;

    // Basic sample with handshake visibility.
    @(negedge clock);
    LEFT = 18'sd1000; RIGHT = 18'sd500; Ks = 4'd8; Kd = 4'd8; sample_valid = 1'b1;
    @(posedge clock);
    #1 sample_valid = 1'b0;
    chk("t1_start_pulse", mult_start, 1);
    chk("t1_mult_a_sum", mult_a, 1500);
    chk("t1_mult_b_ks", mult_b, 8);
    chk("t1_busy", busy, 1);
    @(posedge clock);
    #1 chk("t1_start_oneshot", mult_start, 0);
    chk("t1_mult_a_hold", mult_a, 1500);
    cyc = 2;
    while (!out_valid && cyc < 100) begin
      @(posedge clock);
      #1 cyc++;
    end
    chk("t1_latency", cyc, 11);
    chk("t1_lpr", LI_in_LpR, 1500);
    chk("t1_lmr", LI_in_LmR, 500);
    chk("t1_busy_done", busy, 0);
    @(posedge clock);
    #1 chk("t1_valid_pulse", out_valid, 0);
    chk("t1_lpr_hold", LI_in_LpR, 1500);

    // Positive saturation, then a back-to-back sample accepted in the out_valid cycle.
    run_sample(18'sd100000, 18'sd100000, 4'd15, 4'd15, cyc);
    chk("t2_latency", cyc, 11);
    chk("t2_lpr_sat", LI_in_LpR, 131071);
    chk("t2_lmr", LI_in_LmR, 0);
    run_sample(-18'sd100000, 18'sd100000, 4'd15, 4'd15, cyc);
    chk("t3_latency_b2b", cyc, 11);
    chk("t3_lpr", LI_in_LpR, 0);
    chk("t3_lmr_sat", LI_in_LmR, -131072);

    // Rounding behaviour on small negative/positive products.
    run_sample(18'sd1, 18'sd4, 4'd1, 4'd1, cyc);
    chk("t4_latency", cyc, 11);
`ifdef SF_ROUND_EN
    chk("t4_lpr_round", LI_in_LpR, 1);
    chk("t4_lmr_round", LI_in_LmR, 0);
`else
    chk("t4_lpr_trunc", LI_in_LpR, 0);
    chk("t4_lmr_trunc", LI_in_LmR, -1);
`endif

    // Zero gain forces an exact zero.
    run_sample(18'sd1000, 18'sd500, 4'd0, 4'd8, cyc);
    chk("t5_lpr_zero_gain", LI_in_LpR, 0);
    chk("t5_lmr", LI_in_LmR, 500);

    // Overrun: second strobe two cycles after the start pulse is dropped.
    @(negedge clock);
    LEFT = 18'sd1000; RIGHT = 18'sd500; Ks = 4'd8; Kd = 4'd8; sample_valid = 1'b1;
    @(posedge clock);
    #1 sample_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 LEFT = 18'sd5; RIGHT = 18'sd5; Ks = 4'd1; Kd = 4'd1; sample_valid = 1'b1;
    @(posedge clock);
    #1 sample_valid = 1'b0;
    chk("t6_overrun", overrun, 1);
    chk("t6_mult_a_kept", mult_a, 1500);
    @(posedge clock);
    #1 chk("t6_overrun_pulse", overrun, 0);
    cyc = 5;
    while (!out_valid && cyc < 100) begin
      @(posedge clock);
      #1 cyc++;
    end
    chk("t6_latency", cyc, 11);
    chk("t6_lpr", LI_in_LpR, 1500);
    chk("t6_lmr", LI_in_LmR, 500);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1 if (out_valid) pulses++;
    end
    chk("t6_no_second_valid", pulses, 0);

    // Early ready (Tm=1) is ignored until TM_MIN cycles have elapsed.
    tm_model = 1;
    run_sample(18'sd1000, 18'sd500, 4'd8, 4'd8, cyc);
    chk("t7_latency_tmmin", cyc, 7);
    chk("t7_lpr", LI_in_LpR, 1500);
    chk("t7_lmr", LI_in_LmR, 500);
    tm_model = 4;

    // Asynchronous reset during WAIT_D, then normal operation.
    @(negedge clock);
    LEFT = -18'sd2000; RIGHT = 18'sd300; Ks = 4'd3; Kd = 4'd5; sample_valid = 1'b1;
    @(posedge clock);
    #1 sample_valid = 1'b0;
    repeat (8) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t8_rst_busy", busy, 0);
    chk("t8_rst_lpr", LI_in_LpR, 0);
    chk("t8_rst_lmr", LI_in_LmR, 0);
    chk("t8_rst_mult_a", mult_a, 0);
    chk("t8_rst_mult_b", mult_b, 0);
    chk("t8_rst_out_valid", out_valid, 0);
    @(negedge clock) reset = 1'b0;
    run_sample(18'sd1000, 18'sd500, 4'd8, 4'd8, cyc);
    chk("t8_latency", cyc, 11);
    chk("t8_lpr", LI_in_LpR, 1500);
    chk("t8_lmr", LI_in_LmR, 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
